vscale_fwb_queue: RTL and testbench

VSCALE_FWB_QUEUE -- requirements
Module: vscale_fwb_queue

---
 rtl/vscale_fwb_queue_pkg.sv | 20 ++
 rtl/vscale_fwb_fifo.sv | 62 ++++++
 rtl/vscale_fwb_queue.sv | 126 ++++++++++++
 tb/tb_vscale_fwb_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_fwb_queue_pkg.sv
// Shared FP writeback package: datapath widths, FIFO depth and the
// buffered-result entry type used by the writeback queue and its FIFO.
// XPR_LEN and REG_ADDR_WIDTH carry the same values as rv32_opcodes.vh.
package vscale_fwb_queue_pkg;

  localparam int unsigned XPR_LEN        = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned NUM_FP_REGS    = 1 << REG_ADDR_WIDTH;
  localparam int unsigned FWB_DEPTH      = 2;
  localparam int unsigned FWB_CNT_W      = $clog2(FWB_DEPTH + 1);
  localparam int unsigned FWB_PTR_W      = 1;
  localparam int unsigned NUM_CHK_OPS    = 3;

  // One buffered FPU result awaiting a regfile write slot.
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] wa;
    logic [XPR_LEN-1:0]        wd;
  } fwb_entry_t;

endpackage

// File: rtl/vscale_fwb_fifo.sv
// Two-entry in-order FIFO for FPU results.
// Ports: clk, reset (async, active high); push_valid/push_data (push is
// dropped when full, caller checks count); pop_ready, pop_valid_c,
// pop_data_c (head, combinational from storage); count (occupancy).
// A push is never visible at the head in the same cycle (no fall-through).
module vscale_fwb_fifo
  import vscale_fwb_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_valid,
  input  fwb_entry_t           push_data,
  input  logic                 pop_ready,
  output logic                 pop_valid_c,
  output fwb_entry_t           pop_data_c,
  output logic [FWB_CNT_W-1:0] count
);

  fwb_entry_t           mem [FWB_DEPTH];
  logic [FWB_PTR_W-1:0] rd_ptr;
  logic [FWB_PTR_W-1:0] wr_ptr;
  logic [FWB_CNT_W-1:0] count_next;
  logic                 push;
  logic                 pop;

  assign pop_valid_c = (count != '0);
  assign pop_data_c  = mem[rd_ptr];
  assign push        = push_valid && (count < FWB_CNT_W'(FWB_DEPTH));
  assign pop         = pop_ready && pop_valid_c;

  // Occupancy update; push+pop together leaves count unchanged.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + FWB_CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - FWB_CNT_W'(1);
    end
  end

  // Pointers, occupancy and storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(FWB_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      count <= count_next;
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + FWB_PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FWB_PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/vscale_fwb_queue.sv
// FP writeback queue: arbitrates FLW returns and buffered FPU results onto
// the single FP regfile write port and tracks busy FP registers for decode.
// Ports: clk, reset; iss_* (issued FP op destination); ld_* (FLW return,
// highest priority); fpu_* (FPU result, valid/ready); wen/wa/wd (regfile
// write, combinational); chk_* and hazard (decode scoreboard check).
// Optional: VSCALE_FWB_BYPASS_EN adds byp_hit and masks operands being
// written this cycle from hazard.
module vscale_fwb_queue
  import vscale_fwb_queue_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      iss_valid,
  input  logic [REG_ADDR_WIDTH-1:0] iss_wa,
  input  logic                      ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ld_wa,
  input  logic [XPR_LEN-1:0]        ld_wd,
  input  logic                      fpu_valid,
  output logic                      fpu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] fpu_wa,
  input  logic [XPR_LEN-1:0]        fpu_wd,
  output logic                      wen,
  output logic [REG_ADDR_WIDTH-1:0] wa,
  output logic [XPR_LEN-1:0]        wd,
  input  logic [3:0]                chk_en,
  input  logic [REG_ADDR_WIDTH-1:0] chk_ra1,
  input  logic [REG_ADDR_WIDTH-1:0] chk_ra2,
  input  logic [REG_ADDR_WIDTH-1:0] chk_ra3,
  input  logic [REG_ADDR_WIDTH-1:0] chk_wa,
  output logic                      hazard
`ifdef VSCALE_FWB_BYPASS_EN
  ,
  output logic [NUM_CHK_OPS-1:0]    byp_hit
`endif
);

  logic                      fifo_valid;
  fwb_entry_t                fifo_head;
  fwb_entry_t                fifo_in;
  logic [FWB_CNT_W-1:0]      fifo_count;
  logic [NUM_FP_REGS-1:0]    busy;
  logic [NUM_FP_REGS-1:0]    busy_next;
  logic [REG_ADDR_WIDTH-1:0] op_addr [NUM_CHK_OPS];
  logic [NUM_CHK_OPS-1:0]    op_masked;

  assign fpu_ready = (fifo_count < FWB_CNT_W'(FWB_DEPTH));
  assign fifo_in   = '{wa: fpu_wa, wd: fpu_wd};

  // A load owns the write port, so the FIFO head simply waits.
  vscale_fwb_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (fpu_valid && fpu_ready),
    .push_data   (fifo_in),
    .pop_ready   (!ld_valid),
    .pop_valid_c (fifo_valid),
    .pop_data_c  (fifo_head),
    .count       (fifo_count)
  );

  // Write-port arbitration: load first, then FIFO head.
  always_comb begin
    wen = 1'b0;
    wa  = '0;
    wd  = '0;
    if (ld_valid) begin
      wen = 1'b1;
      wa  = ld_wa;
      wd  = ld_wd;
    end else if (fifo_valid) begin
      wen = 1'b1;
      wa  = fifo_head.wa;
      wd  = fifo_head.wd;
    end
  end

  // Busy scoreboard; a same-cycle issue to the written register wins.
  always_comb begin
    busy_next = busy;
    if (wen) begin
      busy_next[wa] = 1'b0;
    end
    if (iss_valid) begin
      busy_next[iss_wa] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign op_addr[0] = chk_ra1;
  assign op_addr[1] = chk_ra2;
  assign op_addr[2] = chk_ra3;

`ifdef VSCALE_FWB_BYPASS_EN
  // Operands being written this cycle can take wd directly.
  always_comb begin
    byp_hit = '0;
    for (int i = 0; i < int'(NUM_CHK_OPS); i++) begin
      byp_hit[i] = chk_en[i] && wen && (op_addr[i] == wa);
    end
  end
  assign op_masked = byp_hit;
`else
  assign op_masked = '0;
`endif

  // Source operands plus destination (keeps FP writeback in order).
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(NUM_CHK_OPS); i++) begin
      if (chk_en[i] && busy[op_addr[i]] && !op_masked[i]) begin
        hazard = 1'b1;
      end
    end
    if (chk_en[3] && busy[chk_wa]) begin
      hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_vscale_fwb_queue.sv
// Directed self-checking bench for vscale_fwb_queue. Works with or without
// VSCALE_FWB_BYPASS_EN; expectations follow the macro.
module tb_vscale_fwb_queue;

`ifdef VSCALE_FWB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_wa;
  logic        ld_valid;
  logic [4:0]  ld_wa;
  logic [31:0] ld_wd;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_wa;
  logic [31:0] fpu_wd;
  logic        wen;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [3:0]  chk_en;
  logic [4:0]  chk_ra1;
  logic [4:0]  chk_ra2;
  logic [4:0]  chk_ra3;
  logic [4:0]  chk_wa;
  logic        hazard;
`ifdef VSCALE_FWB_BYPASS_EN
  logic [2:0]  byp_hit;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vscale_fwb_queue dut (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_wa    (iss_wa),
    .ld_valid  (ld_valid),
    .ld_wa     (ld_wa),
    .ld_wd     (ld_wd),
    .fpu_valid (fpu_valid),
    .fpu_ready (fpu_ready),
    .fpu_wa    (fpu_wa),
    .fpu_wd    (fpu_wd),
    .wen       (wen),
    .wa        (wa),
    .wd        (wd),
    .chk_en    (chk_en),
    .chk_ra1   (chk_ra1),
    .chk_ra2   (chk_ra2),
    .chk_ra3   (chk_ra3),
    .chk_wa    (chk_wa),
    .hazard    (hazard)
`ifdef VSCALE_FWB_BYPASS_EN
    ,
    .byp_hit   (byp_hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    iss_valid = 1'b0; iss_wa  = '0;
    ld_valid  = 1'b0; ld_wa   = '0; ld_wd  = '0;
    fpu_valid = 1'b0; fpu_wa  = '0; fpu_wd = '0;
    chk_en    = '0;   chk_ra1 = '0; chk_ra2 = '0; chk_ra3 = '0; chk_wa = '0;
  endtask

  task automatic write_chk(input string tag, input logic [4:0] exp_wa, input logic [31:0] exp_wd);
    check({tag, "_wen"}, 64'(wen), 64'(1));
    check({tag, "_wa"},  64'(wa), 64'(exp_wa));
    check({tag, "_wd"},  64'(wd), 64'(exp_wd));
  endtask

  initial begin
    clr_inputs();
    reset  = 1'b1;
    chk_en = 4'hF;
    #1;
    check("rst_ready", 64'(fpu_ready), 64'(1));
    check("rst_wen",   64'(wen), 64'(0));
    check("rst_hazard", 64'(hazard), 64'(0));
    step(); step();
    reset  = 1'b0;
    chk_en = '0;
    #1;
    check("post_rst_wen", 64'(wen), 64'(0));

    // Issue f3, result 4 cycles later, hazard until write
    iss_valid = 1'b1; iss_wa = 5'd3;
    step();
    iss_valid = 1'b0;
    chk_en = 4'b0001; chk_ra1 = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1; check("f3_busy_hazard", 64'(hazard), 64'(1));
      step();
    end
    chk_en = 4'b1000; chk_wa = 5'd3;
    #1; check("f3_waw_hazard", 64'(hazard), 64'(1));
    chk_en = 4'b0001;
    fpu_valid = 1'b1; fpu_wa = 5'd3; fpu_wd = 32'h3F80_0000;
    #1;
    check("f3_push_ready", 64'(fpu_ready), 64'(1));
    check("f3_no_fallthru", 64'(wen), 64'(0));
    step();
    fpu_valid = 1'b0;
    #1;
    write_chk("f3_write", 5'd3, 32'h3F80_0000);
    check("f3_write_hazard", 64'(hazard), 64'(!BYP));
    step();
    #1;
    check("f3_done_wen", 64'(wen), 64'(0));
    check("f3_done_hazard", 64'(hazard), 64'(0));
    chk_en = '0;

    // Fill the FIFO behind two loads, third result waits for a pop
    ld_valid = 1'b1; ld_wa = 5'd20; ld_wd = 32'h14;
    fpu_valid = 1'b1; fpu_wa = 5'd10; fpu_wd = 32'hA0;
    #1;
    write_chk("fill_ld20", 5'd20, 32'h14);
    check("fill_ready0", 64'(fpu_ready), 64'(1));
    step();
    ld_wa = 5'd21; ld_wd = 32'h15;
    fpu_wa = 5'd11; fpu_wd = 32'hB0;
    #1;
    write_chk("fill_ld21", 5'd21, 32'h15);
    check("fill_ready1", 64'(fpu_ready), 64'(1));
    step();
    ld_valid = 1'b0;
    fpu_wa = 5'd12; fpu_wd = 32'hC0;
    #1;
    check("full_ready", 64'(fpu_ready), 64'(0));
    write_chk("full_pop10", 5'd10, 32'hA0);
    step();
    #1;
    check("third_ready", 64'(fpu_ready), 64'(1));
    write_chk("pop11", 5'd11, 32'hB0);
    step();
    fpu_valid = 1'b0;
    #1;
    write_chk("pop12", 5'd12, 32'hC0);
    step();
    #1;
    check("drain_wen", 64'(wen), 64'(0));
    check("drain_ready", 64'(fpu_ready), 64'(1));

    // Back-to-back results with no loads stream through one entry
    fpu_valid = 1'b1; fpu_wa = 5'd13; fpu_wd = 32'hD0;
    step();
    fpu_wa = 5'd14; fpu_wd = 32'hE0;
    #1;
    write_chk("b2b_13", 5'd13, 32'hD0);
    check("b2b_ready", 64'(fpu_ready), 64'(1));
    step();
    fpu_wa = 5'd15; fpu_wd = 32'hF0;
    #1;
    write_chk("b2b_14", 5'd14, 32'hE0);
    step();
    fpu_valid = 1'b0;
    #1;
    write_chk("b2b_15", 5'd15, 32'hF0);
    step();
    #1;
    check("b2b_idle", 64'(wen), 64'(0));

    // Load to f5 preempts FIFO head f6
    iss_valid = 1'b1; iss_wa = 5'd5;
    step();
    iss_wa = 5'd6;
    step();
    iss_valid = 1'b0;
    fpu_valid = 1'b1; fpu_wa = 5'd6; fpu_wd = 32'h4040_0000;
    step();
    fpu_valid = 1'b0;
    ld_valid = 1'b1; ld_wa = 5'd5; ld_wd = 32'h4000_0000;
    chk_en = 4'b0010; chk_ra2 = 5'd6;
    #1;
    write_chk("ld_first", 5'd5, 32'h4000_0000);
    check("ld_f6_hazard", 64'(hazard), 64'(1));
    check("ld_ready", 64'(fpu_ready), 64'(1));
    step();
    ld_valid = 1'b0;
    chk_en = '0;
    #1;
    write_chk("f6_after_ld", 5'd6, 32'h4040_0000);
    step();
    chk_en = 4'b0011; chk_ra1 = 5'd5; chk_ra2 = 5'd6;
    #1;
    check("ld_done_wen", 64'(wen), 64'(0));
    check("ld_done_hazard", 64'(hazard), 64'(0));
    chk_en = '0;

    // Reissue of f7 in its write cycle keeps it busy
    iss_valid = 1'b1; iss_wa = 5'd7;
    step();
    iss_valid = 1'b0;
    fpu_valid = 1'b1; fpu_wa = 5'd7; fpu_wd = 32'h77;
    step();
    fpu_valid = 1'b0;
    iss_valid = 1'b1; iss_wa = 5'd7;
    #1;
    write_chk("f7_write", 5'd7, 32'h77);
    step();
    iss_valid = 1'b0;
    chk_en = 4'b0010; chk_ra2 = 5'd7;
    #1;
    check("f7_set_wins", 64'(hazard), 64'(1));
    chk_en = '0;

    // Write to f9 while ra3=9 is checked
    iss_valid = 1'b1; iss_wa = 5'd9;
    step();
    iss_valid = 1'b0;
    fpu_valid = 1'b1; fpu_wa = 5'd9; fpu_wd = 32'h4110_0000;
    step();
    fpu_valid = 1'b0;
    chk_en = 4'b0100; chk_ra3 = 5'd9;
    #1;
    write_chk("f9_write", 5'd9, 32'h4110_0000);
    check("f9_hazard", 64'(hazard), 64'(!BYP));
`ifdef VSCALE_FWB_BYPASS_EN
    check("f9_byp_hit", 64'(byp_hit), 64'(3'b100));
`endif
    step();
    #1;
    check("f9_after_hazard", 64'(hazard), 64'(0));
    chk_en = '0;

    // Async reset with FIFO full and busy bits set
    iss_valid = 1'b1; iss_wa = 5'd1;
    step();
    iss_wa = 5'd2;
    step();
    iss_valid = 1'b0;
    ld_valid = 1'b1; ld_wa = 5'd25; ld_wd = 32'h25;
    fpu_valid = 1'b1; fpu_wa = 5'd1; fpu_wd = 32'h11;
    step();
    fpu_wa = 5'd2; fpu_wd = 32'h22;
    step();
    ld_valid = 1'b0; fpu_valid = 1'b0;
    chk_en = 4'b0011; chk_ra1 = 5'd1; chk_ra2 = 5'd2;
    #1;
    check("pre_rst_hazard", 64'(hazard), 64'(1));
    check("pre_rst_ready", 64'(fpu_ready), 64'(0));
    write_chk("pre_rst_head", 5'd1, 32'h11);
    reset = 1'b1;
    #1;
    check("async_rst_wen", 64'(wen), 64'(0));
    check("async_rst_ready", 64'(fpu_ready), 64'(1));
    check("async_rst_hazard", 64'(hazard), 64'(0));
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_nowrite", 64'(wen), 64'(0));
      check("post_rst_hazard", 64'(hazard), 64'(0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
